// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side controller.
// Imported by fifo_out_buf and fifo_reader.
package fifo_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

    localparam int FIFO_RD_LATENCY = 1;
    localparam int FIFO_DATA_WIDTH = 32;

endpackage

// File: rtl/fifo_out_buf.sv
// Small register queue that catches words popped from the FIFO.
// Push is ignored when full (unless a pop frees a slot) and reported on overflow_o.
module fifo_out_buf
    import fifo_pkg::*;
#(
    parameter int  DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int  BUF_DEPTH  = 2,
    localparam int PTR_W      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1,
    localparam int OCC_W      = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] push_data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic [OCC_W-1:0]      occ_o,
    output logic                  overflow_o
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [OCC_W-1:0]      occ_q, occ_d;
    logic                  full_s, empty_s, do_push_s, do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(BUF_DEPTH - 1)) begin
            ptr_inc = PTR_W'(0);
        end else begin
            ptr_inc = p + PTR_W'(1);
        end
    endfunction

    // Push/pop qualification, pointer and occupancy next-state
    always_comb begin
        full_s    = (occ_q == OCC_W'(BUF_DEPTH));
        empty_s   = (occ_q == OCC_W'(0));
        do_pop_s  = pop_i & ~empty_s;
        do_push_s = push_i & (~full_s | do_pop_s);
        rd_ptr_d  = do_pop_s  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d  = do_push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
    end

    assign head_o     = mem_q[rd_ptr_q];
    assign occ_o      = occ_q;
    assign overflow_o = push_i & full_s & ~do_pop_s;

    // Queue storage, pointers and occupancy
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= PTR_W'(0);
            wr_ptr_q <= PTR_W'(0);
            occ_q    <= OCC_W'(0);
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= push_data_i;
            end
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// Read-side controller for the single-clock FIFO: pops words, hides the read
// latency behind a small buffer, streams them out on valid/ready, supports drain.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int BUF_DEPTH  = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  Clock,
    input  logic                  Reset_,
    input  logic                  Enable,
    input  logic                  DrainReq,
    input  logic                  Empty_,
    input  logic [DATA_WIDTH-1:0] FifoData,
    output logic                  ReadEn,
    output logic [DATA_WIDTH-1:0] OutData,
    output logic                  OutValid,
    input  logic                  OutReady,
    output logic                  DrainDone,
    output logic [CNT_WIDTH-1:0]  WordCount,
    output logic                  Error
);

    localparam int OCC_W = $clog2(BUF_DEPTH + 1);
    localparam int LVL_W = OCC_W + 1;

    rd_state_t             state_q, state_d;
    logic                  inflight_q, inflight_d;
    logic                  drain_done_q, drain_done_d;
    logic                  error_q, error_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [OCC_W-1:0]      occ_s;
    logic [DATA_WIDTH-1:0] head_s;
    logic [LVL_W-1:0]      level_s;
    logic                  buf_empty_s, fire_s, buf_push_s, buf_pop_s, overflow_s;
    logic                  drain_empty_s, drain_misuse_s;

    fifo_out_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .BUF_DEPTH  (BUF_DEPTH)
    ) u_out_buf (
        .clk_i       (Clock),
        .rst_ni      (Reset_),
        .push_i      (buf_push_s),
        .push_data_i (FifoData),
        .pop_i       (buf_pop_s),
        .head_o      (head_s),
        .occ_o       (occ_s),
        .overflow_o  (overflow_s)
    );

    // The word landing from the FIFO this cycle counts as buffered and is
    // presented directly when the queue is empty; only unaccepted words are queued.
    always_comb begin
        buf_empty_s = (occ_s == OCC_W'(0));
        level_s     = LVL_W'(occ_s) + LVL_W'(inflight_q);
        ReadEn      = ((state_q == RUN) || (state_q == DRAIN)) & Empty_ &
                      (level_s < LVL_W'(BUF_DEPTH));
        OutValid    = ~buf_empty_s | inflight_q;
        if (!buf_empty_s) begin
            OutData = head_s;
        end else if (inflight_q) begin
            OutData = FifoData;
        end else begin
            OutData = {DATA_WIDTH{1'b0}};
        end
        fire_s        = OutValid & OutReady;
        buf_pop_s     = fire_s & ~buf_empty_s;
        buf_push_s    = inflight_q & ~(buf_empty_s & OutReady);
        drain_empty_s = (level_s == LVL_W'(fire_s));
    end

    // Controller next state; a repeated drain request is flagged and otherwise ignored
    always_comb begin
        state_d        = state_q;
        drain_misuse_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (DrainReq) begin
                    state_d = DRAIN;
                end else if (Enable) begin
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (DrainReq) begin
                    state_d = DRAIN;
                end else if (!Enable) begin
                    state_d = IDLE;
                end else begin
                    state_d = RUN;
                end
            end
            DRAIN: begin
                drain_misuse_s = DrainReq;
                if (!Empty_ && !ReadEn && drain_empty_s) begin
                    state_d = DONE;
                end else begin
                    state_d = DRAIN;
                end
            end
            DONE: begin
                drain_misuse_s = DrainReq;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next values for the in-flight flag, done pulse, sticky error and counter
    always_comb begin
        inflight_d   = ReadEn;
        drain_done_d = (state_d == DONE);
        error_d      = error_q | drain_misuse_s | overflow_s;
        count_d      = fire_s ? (count_q + CNT_WIDTH'(1)) : count_q;
    end

    // Controller registers
    always_ff @(posedge Clock or negedge Reset_) begin
        if (!Reset_) begin
            state_q      <= IDLE;
            inflight_q   <= 1'b0;
            drain_done_q <= 1'b0;
            error_q      <= 1'b0;
            count_q      <= CNT_WIDTH'(0);
        end else begin
            state_q      <= state_d;
            inflight_q   <= inflight_d;
            drain_done_q <= drain_done_d;
            error_q      <= error_d;
            count_q      <= count_d;
        end
    end

    assign DrainDone = drain_done_q;
    assign WordCount = count_q;
    assign Error     = error_q;

endmodule
